// File: rtl/parity_scan_pkg.sv
// Shared definitions for the parity scan engine: FSM state encoding and parity-mode constants.
package parity_scan_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StPresent,
    StFinish
  } scan_state_e;

  // Target value of the XOR over a stored word for it to count as good.
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/scan_bank_mem.sv
// Banked word storage: one write port and one registered (one-cycle latency) read port.
module scan_bank_mem #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned BANK_W    = 1,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [BANK_W-1:0] i_wr_bank,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [BANK_W-1:0] i_rd_bank,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [NUM_BANKS][DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
  end

  // Only the read register is reset; the array contents are left as they are.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_bank][i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/parity_scan_engine.sv
// Walks every word of a banked memory, checks its parity, presents each word with a
// valid/ready handshake and counts mismatches; supports continuous rescans and abort.
module parity_scan_engine
  import parity_scan_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned ODD_PARITY = 0,
  parameter int unsigned ERR_W      = 8,
  localparam int unsigned BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [BANK_W-1:0] out_bank,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_ok,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic PARITY_TARGET = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

  scan_state_e       r_state, w_state_next;
  logic [BANK_W-1:0] r_bank;
  logic [ADDR_W-1:0] r_addr;
  logic [ERR_W-1:0]  r_err;
  logic              r_cont;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_en;
  logic              w_mem_we;
  logic              w_parity_ok;
  logic              w_last;
  logic              w_xfer;

  assign w_last      = (r_bank == BANK_W'(NUM_BANKS - 1)) && (r_addr == ADDR_W'(DEPTH - 1));
  assign w_xfer      = (r_state == StPresent) && out_ready && !abort;
  assign w_parity_ok = ((^w_rd_data) == PARITY_TARGET);
  assign w_mem_we    = wr_en && (r_state == StIdle);

  scan_bank_mem #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .NUM_BANKS(NUM_BANKS),
    .BANK_W   (BANK_W),
    .ADDR_W   (ADDR_W)
  ) u_mem (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_wr_en  (w_mem_we),
    .i_wr_bank(wr_bank),
    .i_wr_addr(wr_addr),
    .i_wr_data(wr_data),
    .i_rd_en  (w_rd_en),
    .i_rd_bank(r_bank),
    .i_rd_addr(r_addr),
    .o_rd_data(w_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (start) w_state_next = StRead;
      StRead:    w_state_next = abort ? StIdle : StPresent;
      StPresent: begin
        if (abort) begin
          w_state_next = StIdle;
        end else if (out_ready) begin
          w_state_next = w_last ? StFinish : StRead;
        end
      end
      StFinish:  w_state_next = (abort || !r_cont) ? StIdle : StRead;
      default:   w_state_next = StIdle;
    endcase
  end

  // A wrapping continuous scan is not a scan end, so it does not pulse done.
  always_comb begin
    out_valid = (r_state == StPresent);
    busy      = (r_state != StIdle);
    done      = (r_state == StFinish) && !r_cont && !abort;
    out_ok    = out_valid && w_parity_ok;
    w_rd_en   = (r_state == StRead);
  end

  // cont is re-sampled on the last transfer of each pass, which decides the wrap in StFinish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bank <= '0;
      r_addr <= '0;
      r_err  <= '0;
      r_cont <= 1'b0;
    end else if ((r_state == StIdle) && start) begin
      r_bank <= '0;
      r_addr <= '0;
      r_err  <= '0;
      r_cont <= cont;
    end else if (w_xfer) begin
      if (!w_parity_ok && (r_err != '1)) begin
        r_err <= r_err + ERR_W'(1);
      end
      if (w_last) begin
        r_bank <= '0;
        r_addr <= '0;
        r_cont <= cont;
      end else if (r_addr == ADDR_W'(DEPTH - 1)) begin
        r_addr <= '0;
        r_bank <= r_bank + BANK_W'(1);
      end else begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  assign out_data  = w_rd_data;
  assign out_bank  = r_bank;
  assign out_addr  = r_addr;
  assign err_count = r_err;

endmodule

// File: tb/tb_parity_scan_engine.sv
// Scoreboard bench: a default (even parity) engine and an odd-parity, 2-bit-counter engine
// share one stimulus stream; expected words are queued at start and popped on each transfer.
module tb_parity_scan_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       abort = 1'b0;
  logic       wr_en = 1'b0;
  logic [0:0] wr_bank = '0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       out_ready = 1'b0;

  logic       v1, ok1, busy1, done1;
  logic [7:0] d1, err1;
  logic [0:0] b1;
  logic [2:0] a1;
  logic       v2, ok2, busy2, done2;
  logic [7:0] d2;
  logic [1:0] err2;
  logic [0:0] b2;
  logic [2:0] a2;

  parity_scan_engine u_dut_even (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .abort(abort),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_bank(b1), .out_addr(a1),
    .out_ok(ok1), .busy(busy1), .done(done1), .err_count(err1)
  );

  parity_scan_engine #(
    .ODD_PARITY(1),
    .ERR_W     (2)
  ) u_dut_odd (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .abort(abort),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(v2), .out_ready(out_ready), .out_data(d2), .out_bank(b2), .out_addr(a2),
    .out_ok(ok2), .busy(busy2), .done(done2), .err_count(err2)
  );

  typedef struct packed {
    logic [0:0] bank;
    logic [2:0] addr;
    logic [7:0] data;
    logic       ok;
  } exp_t;

  exp_t       q1[$];
  exp_t       q2[$];
  exp_t       e1, e2;
  logic [7:0] mdl [2][8];
  logic [7:0] exp_err1;
  logic [1:0] exp_err2;
  int         n_err = 0;
  int         n_chk = 0;
  int         xfer_cnt = 0;
  int         done_cnt = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Sample just before each rising edge, where a transfer is decided.
  always @(negedge clk) begin
    #4;
    if (!reset) begin
      if (done1) done_cnt++;
      if (v1 && out_ready && !abort) begin
        xfer_cnt++;
        if (q1.size() == 0 || q2.size() == 0) begin
          check("sb_underflow", 32'(q1.size()), 32'd1);
        end else begin
          e1 = q1.pop_front();
          e2 = q2.pop_front();
          check("data_even", 32'(d1), 32'(e1.data));
          check("bank", 32'(b1), 32'(e1.bank));
          check("addr", 32'(a1), 32'(e1.addr));
          check("ok_even", 32'(ok1), 32'(e1.ok));
          check("valid_odd", 32'(v2), 32'd1);
          check("data_odd", 32'(d2), 32'(e2.data));
          check("ok_odd", 32'(ok2), 32'(e2.ok));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic write_word(input int b, input int a, input logic [7:0] d);
    tick();
    wr_en   = 1'b1;
    wr_bank = 1'(b);
    wr_addr = 3'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    mdl[b][a] = d;
  endtask

  task automatic push_scan(input int passes);
    exp_t e;
    exp_err1 = '0;
    exp_err2 = '0;
    for (int p = 0; p < passes; p++) begin
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < 8; a++) begin
          e.bank = 1'(b);
          e.addr = 3'(a);
          e.data = mdl[b][a];
          e.ok   = ((^mdl[b][a]) == 1'b0);
          q1.push_back(e);
          if (!e.ok && exp_err1 != 8'hFF) exp_err1++;
          e.ok = ((^mdl[b][a]) == 1'b1);
          q2.push_back(e);
          if (!e.ok && exp_err2 != 2'b11) exp_err2++;
        end
      end
    end
  endtask

  task automatic start_scan(input logic c);
    tick();
    start = 1'b1;
    cont  = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      tick();
      cycles++;
      if (!busy1) break;
    end
    if (busy1) check("idle_timeout", 32'(busy1), 32'd0);
  endtask

  task automatic check_end(input string tag, input int dbase, input int xbase, input int xn);
    check({tag, "_err_even"}, 32'(err1), 32'(exp_err1));
    check({tag, "_err_odd"}, 32'(err2), 32'(exp_err2));
    check({tag, "_done"}, 32'(done_cnt - dbase), 32'd1);
    check({tag, "_xfers"}, 32'(xfer_cnt - xbase), 32'(xn));
    check({tag, "_sb_left"}, 32'(q1.size()), 32'd0);
  endtask

  initial begin
    int cyc, dbase, xbase, k;
    bit seen;

    // Reset values
    tick();
    tick();
    check("rst_valid", 32'(v1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_err", 32'(err1), 32'd0);
    check("rst_data", 32'(d1), 32'd0);
    check("rst_bank_addr", 32'({b1, a1}), 32'd0);
    check("rst_ok", 32'(ok1), 32'd0);
    reset = 1'b0;

    for (int b = 0; b < 2; b++) for (int a = 0; a < 8; a++) write_word(b, a, 8'h00);
    write_word(0, 0, 8'hD9);
    write_word(1, 0, 8'h66);

    // Single pass; first result held under back-pressure for 5 cycles
    dbase = done_cnt;
    xbase = xfer_cnt;
    push_scan(1);
    out_ready = 1'b0;
    start_scan(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (v1) seen = 1'b1;
      else tick();
    end
    check("first_valid_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(v1), 32'd1);
      check("hold_data", 32'(d1), 32'(q1[0].data));
      check("hold_bank_addr", 32'({b1, a1}), 32'({q1[0].bank, q1[0].addr}));
      check("hold_ok", 32'(ok1), 32'(q1[0].ok));
      check("hold_no_xfer", 32'(xfer_cnt - xbase), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_idle(100, cyc);
    check_end("pass1", dbase, xbase, 16);

    // Continuous mode, cont dropped during the second pass
    dbase = done_cnt;
    xbase = xfer_cnt;
    push_scan(2);
    start_scan(1'b1);
    k = 0;
    while (busy1 && k < 200) begin
      tick();
      k++;
      if (xfer_cnt >= xbase + 20) cont = 1'b0;
    end
    check("cont_idle", 32'(busy1), 32'd0);
    check_end("cont", dbase, xbase, 32);

    // Abort in PRESENT at b0a3, with a write attempted mid-scan
    dbase = done_cnt;
    push_scan(1);
    out_ready = 1'b0;
    start_scan(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      out_ready = 1'b0;
      wr_en = 1'b0;
      if (v1) begin
        if (a1 == 3'd3) begin
          check("abort_at_bank0", 32'(b1), 32'd0);
          abort = 1'b1;
          tick();
          abort = 1'b0;
          check("abort_valid", 32'(v1), 32'd0);
          check("abort_busy", 32'(busy1), 32'd0);
          seen = 1'b1;
        end else begin
          out_ready = 1'b1;
          if (a1 == 3'd1) begin
            wr_en   = 1'b1;
            wr_bank = 1'b1;
            wr_addr = 3'd0;
            wr_data = 8'hFF;
          end
        end
      end
    end
    wr_en = 1'b0;
    check("abort_reached", 32'(seen), 32'd1);
    tick();
    check("abort_no_done", 32'(done_cnt - dbase), 32'd0);
    q1.delete();
    q2.delete();

    // Full rescan: memory unchanged by the blocked write; 2 cycles per word
    dbase = done_cnt;
    xbase = xfer_cnt;
    push_scan(1);
    out_ready = 1'b1;
    start_scan(1'b0);
    wait_idle(100, cyc);
    check("scan_cycles", 32'(cyc), 32'd33);
    check_end("rescan", dbase, xbase, 16);

    // All words 8'h01: odd-parity engine all good, even engine all bad
    for (int b = 0; b < 2; b++) for (int a = 0; a < 8; a++) write_word(b, a, 8'h01);
    dbase = done_cnt;
    xbase = xfer_cnt;
    push_scan(1);
    start_scan(1'b0);
    wait_idle(100, cyc);
    check_end("ones", dbase, xbase, 16);

    // Five bad words for the odd engine: its 2-bit counter saturates
    for (int a = 0; a < 5; a++) write_word(0, a, 8'h00);
    dbase = done_cnt;
    xbase = xfer_cnt;
    push_scan(1);
    start_scan(1'b0);
    wait_idle(100, cyc);
    check_end("sat", dbase, xbase, 16);

    // Asynchronous reset while in READ, mid-scan
    dbase = done_cnt;
    xbase = xfer_cnt;
    push_scan(1);
    start_scan(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (xfer_cnt >= xbase + 7 && busy1 && !v1) seen = 1'b1;
    end
    check("read_reached", 32'(seen), 32'd1);
    check("pre_rst_err", 32'(err1), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy1), 32'd0);
    check("arst_valid", 32'(v1), 32'd0);
    check("arst_err", 32'(err1), 32'd0);
    check("arst_err_odd", 32'(err2), 32'd0);
    check("arst_data", 32'(d1), 32'd0);
    check("arst_bank_addr", 32'({b1, a1}), 32'd0);
    check("arst_ok_done", 32'({ok1, done1}), 32'd0);
    tick();
    reset = 1'b0;
    q1.delete();
    q2.delete();
    tick();
    check("arst_no_done", 32'(done_cnt - dbase), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/parity_scan_engine.md
PARITY_SCAN_ENGINE -- requirements
Module: parity_scan_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8: stored word width; bit DATA_W-1 is the parity bit.
REQ-002 SHALL have parameter DEPTH, default 8: words per bank, power of two, at least 2.
REQ-003 SHALL have parameter NUM_BANKS, default 2: bank count, power of two, at least 1.
REQ-004 SHALL have parameter ODD_PARITY, default 0: 0 selects even parity (XOR of all DATA_W bits = 0 is OK); 1 selects odd parity (XOR = 1 is OK).
REQ-005 SHALL have parameter ERR_W, default 8: mismatch counter width.
REQ-006 SHALL have ports, with reset (asynchronous, active-high) and clock clk first:
  clk  in  1  clock
  reset  in  1  asynchronous active-high reset
  start  in  1  begin scan; honoured in IDLE only
  cont  in  1  continuous mode; sampled at start and at each wrap
  abort  in  1  terminate scan
  wr_en  in  1  memory write strobe; honoured in IDLE only
  wr_bank  in  log2(NUM_BANKS), min 1  write bank
  wr_addr  in  log2(DEPTH)  write address
  wr_data  in  DATA_W  write data
  out_valid  out  1  result valid
  out_ready  in  1  consumer accepts result
  out_data  out  DATA_W  fetched word
  out_bank  out  log2(NUM_BANKS), min 1  bank of result
  out_addr  out  log2(DEPTH)  address of result
  out_ok  out  1  parity matched
  busy  out  1  FSM not in IDLE
  done  out  1  one-cycle pulse at scan end
  err_count  out  ERR_W  mismatches since last start

Function
REQ-007 SHALL implement FSM states IDLE, READ, PRESENT and FINISH.
REQ-008 SHALL move IDLE->READ on start, clearing the scan index to bank 0, address 0 and clearing err_count.
REQ-009 SHALL use synchronous memory reads with one-cycle latency: READ issues the address, and the next cycle enters PRESENT with out_valid=1.
REQ-010 SHALL hold out_data, out_bank, out_addr and out_ok stable while out_valid=1 and out_ready=0.
REQ-011 SHALL treat out_valid&out_ready as the transfer; on transfer, advance the index (address first, then bank) and return to READ, or go to FINISH after the last word (bank NUM_BANKS-1, address DEPTH-1).
REQ-012 SHALL increment err_count on each transferred word with out_ok=0, saturating at all-ones.
REQ-013 SHALL, in FINISH, pulse done for one cycle and return to IDLE when the latched cont=0; when cont=1, wrap the index to 0, keep err_count, and enter READ.
REQ-014 SHALL, on abort in any non-IDLE state, drop out_valid and return to IDLE next cycle without a done pulse; abort has priority over transfer.
REQ-015 SHALL ignore start while busy=1, and ignore wr_en while busy=1 (memory unchanged).
REQ-016 SHALL sustain a throughput of one word per 2 cycles with out_ready held high.
REQ-017 SHALL write wr_data to memory[wr_bank][wr_addr] on the clock edge when wr_en=1 in IDLE.

Reset
REQ-018 SHALL, on reset assertion, immediately force IDLE, out_valid=0, done=0, busy=0, err_count=0, out_data/out_bank/out_addr=0, out_ok=0, and clear the scan index.
REQ-019 SHALL leave memory contents undefined after reset; a reset mid-scan abandons the scan with no done pulse.

Structure
REQ-020 SHALL take the FSM state enumeration and the parity-mode constants from a shared package, parity_scan_pkg.
REQ-021 SHALL place storage in one sub-module, scan_bank_mem: NUM_BANKS x DEPTH x DATA_W, one write port, one synchronous read port.

Verification
REQ-022 Load defaults with bank0[0]=8'hD9 and bank1[0]=8'h66, all other words 8'h00, cont=0, start -> 16 results in order b0a0..b1a7; first result out_ok=0 (5 ones); b1a0 out_ok=1; err_count=1; one done pulse.
REQ-023 Hold out_ready=0 for 5 cycles on the first result -> out_valid and all result fields stay constant; no index advance.
REQ-024 cont=1, then cont drops during the second pass -> err_count accumulates to 2 at the end of pass 2, followed by done and IDLE.
REQ-025 abort during PRESENT at b0a3 -> out_valid=0 next cycle, busy=0, no done; wr_en issued mid-scan leaves memory unchanged.
REQ-026 ODD_PARITY=1 with all words 8'h01 -> all out_ok=1, err_count=0; ERR_W=2 with 5 bad words -> err_count=3.
REQ-027 Assert reset in READ -> all outputs reach reset values immediately, asynchronously to clk.
